// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, ALU controls, FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  function automatic logic [31:0] signext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic rtype_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic logic [2:0] alu_decode(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_if.sv
// Unified memory bus between the core (master) and the instruction/data memory (slave).
interface mips_if;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        we;

  modport master (output adr, output wd, output we, input rd);
  modport slave (input adr, input wd, input we, output rd);
endinterface

// File: rtl/mips_multi.sv
// Multicycle MIPS32 core: state-decoded controller plus PC/IR/MDR/A/B/ALUOut datapath.
module mips_multi
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  mips_if.master bus
);
  logic [3:0]  state, state_next;
  logic [31:0] pc, pc_next, ir, mdr, a, b, aluout;
  logic [31:0] rf [32];

  logic        iord, alusrca, irwrite, pcwrite, branch, regwrite, regdst, memtoreg, memwrite;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [31:0] imm_ext, srca, srcb, aluresult, rd1, rd2, wdata;
  logic        zero, pcen;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_ext = signext(ir[15:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = rtype_ok(funct) ? S_RTYPEEX : S_FETCH;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    iord = 1'b0; alusrca = 1'b0; alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = ALU_ADD;
    irwrite = 1'b0; pcwrite = 1'b0; branch = 1'b0; regwrite = 1'b0; regdst = 1'b0;
    memtoreg = 1'b0; memwrite = 1'b0;
    case (state)
      S_FETCH:   begin alusrcb = 2'b01; irwrite = 1'b1; pcwrite = 1'b1; end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      S_RTYPEEX: begin alusrca = 1'b1; alucontrol = alu_decode(funct); end
      S_RTYPEWB: begin regwrite = 1'b1; regdst = 1'b1; end
      S_BEQEX: begin
        alusrca = 1'b1; alucontrol = ALU_SUB; branch = 1'b1; pcsrc = 2'b01;
      end
      S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX:     begin pcwrite = 1'b1; pcsrc = 2'b10; end
      default: ;
    endcase
  end

  // $0 is hardwired: reads forced to zero here, writes dropped below.
  assign rd1   = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rd2   = (rt == 5'd0) ? 32'h0 : rf[rt];
  assign waddr = regdst ? rd : rt;
  assign wdata = memtoreg ? mdr : aluout;
  assign srca  = alusrca ? a : pc;

  always_comb begin
    case (alusrcb)
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = imm_ext;
      2'b11:   srcb = {imm_ext[29:0], 2'b00};
      default: srcb = b;
    endcase
  end

  always_comb begin
    case (alucontrol)
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_SLT: aluresult = {31'b0, ($signed(srca) < $signed(srcb))};
      default: aluresult = srca + srcb;
    endcase
  end

  assign zero = (aluresult == 32'h0);
  assign pcen = pcwrite | (branch & zero);

  always_comb begin
    case (pcsrc)
      2'b01:   pc_next = aluout;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = aluresult;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pc <= 32'h0;
    else if (pcen) pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (irwrite) ir <= bus.rd;
    mdr    <= bus.rd;
    a      <= rd1;
    b      <= rd2;
    aluout <= aluresult;
  end

  always_ff @(posedge clk) begin
    if (regwrite && (waddr != 5'd0)) rf[waddr] <= wdata;
  end

  assign bus.adr = iord ? aluout : pc;
  assign bus.wd  = b;
  assign bus.we  = memwrite;

endmodule

// File: rtl/top.sv
// Multicycle MIPS system: mips_multi core plus unified word-addressed instruction/data memory.
module top #(
  parameter string       MEMFILE   = "memfile.dat",
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  mips_if bus ();

  mips_multi u_cpu (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0]   ram [MEM_WORDS];
  logic [29:0]   word;
  logic [AW-1:0] idx;
  logic          unused_adr;

  assign word       = bus.adr[31:2] % 30'(MEM_WORDS);
  assign idx        = word[AW-1:0];
  assign unused_adr = ^{word, bus.adr[1:0]};

  assign bus.rd = ram[idx];

  always_ff @(posedge clk) begin
    if (bus.we) ram[idx] <= bus.wd;
  end

  assign writedata = bus.wd;
  assign dataadr   = bus.adr;
  assign memwrite  = bus.we;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: expected stores and fetch addresses queued per program, checked per cycle.
module tb_top;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  typedef struct { int cyc; logic [31:0] adr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] adr; } ft_t;
  wr_t wq[$];
  ft_t fq[$];

  mips_if probe ();
  assign probe.rd = 32'h0;

  top #(
    .MEMFILE   (""),
    .MEM_WORDS (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (probe.wd),
    .dataadr   (probe.adr),
    .memwrite  (probe.we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic exp_wr(input int c, input logic [31:0] adr, input logic [31:0] data);
    wr_t e;
    e.cyc = c; e.adr = adr; e.data = data;
    wq.push_back(e);
  endtask

  task automatic exp_fetch(input int c, input logic [31:0] adr);
    ft_t e;
    e.cyc = c; e.adr = adr;
    fq.push_back(e);
  endtask

  task automatic load_program();
    logic [31:0] img [64];
    foreach (img[i]) img[i] = 32'h0;
    img[0]  = 32'h20020005; // addi $2,$0,5
    img[1]  = 32'h20030040; // addi $3,$0,0x40
    img[2]  = 32'hac62000c; // sw   $2,12($3)   -> 0x4C
    img[3]  = 32'h20040003; // addi $4,$0,3
    img[4]  = 32'h00442822; // sub  $5,$2,$4
    img[5]  = 32'h00443024; // and  $6,$2,$4
    img[6]  = 32'h00443825; // or   $7,$2,$4
    img[7]  = 32'h200affff; // addi $10,$0,-1
    img[8]  = 32'h0140582a; // slt  $11,$10,$0
    img[9]  = 32'h0044602a; // slt  $12,$2,$4
    img[10] = 32'h014a6820; // add  $13,$10,$10
    img[11] = 32'h20000007; // addi $0,$0,7
    img[12] = 32'hac000050; // sw   $0,0x50($0)
    img[13] = 32'h10440005; // beq  $2,$4,+5 (not taken)
    img[14] = 32'h10cb0001; // beq  $6,$11,+1 (taken)
    img[15] = 32'h20050077; // skipped
    img[16] = 32'h8c6e000c; // lw   $14,12($3)
    img[17] = 32'h08000018; // j    0x60
    img[18] = 32'h20050055; // skipped
    img[19] = 32'hdeadbeef;
    img[20] = 32'hdeadbeef;
    img[24] = 32'hfc000000; // unsupported opcode
    img[25] = 32'hac0500c0;
    img[26] = 32'hac0600c4;
    img[27] = 32'hac0700c8;
    img[28] = 32'hac0b00cc;
    img[29] = 32'hac0c00d0;
    img[30] = 32'hac0d00d4;
    img[31] = 32'hac0e00d8;
    img[32] = 32'h01a27820; // add  $15,$13,$2
    img[33] = 32'hac0f00dc;
    img[34] = 32'h08000022; // j    0x88 (halt)
    foreach (img[i]) dut.ram[i] = img[i];

    exp_wr(11,  32'h4c, 32'd5);
    exp_wr(51,  32'h50, 32'd0);
    exp_wr(71,  32'hc0, 32'd2);
    exp_wr(75,  32'hc4, 32'd1);
    exp_wr(79,  32'hc8, 32'd7);
    exp_wr(83,  32'hcc, 32'd1);
    exp_wr(87,  32'hd0, 32'd0);
    exp_wr(91,  32'hd4, 32'hfffffffe);
    exp_wr(95,  32'hd8, 32'd5);
    exp_wr(103, 32'hdc, 32'd3);

    exp_fetch(0,   32'h00);
    exp_fetch(4,   32'h04);
    exp_fetch(8,   32'h08);
    exp_fetch(52,  32'h34);
    exp_fetch(55,  32'h38);
    exp_fetch(58,  32'h40);
    exp_fetch(63,  32'h44);
    exp_fetch(66,  32'h60);
    exp_fetch(68,  32'h64);
    exp_fetch(104, 32'h88);
    exp_fetch(107, 32'h88);
  endtask

  task automatic sample();
    if (fq.size() != 0 && fq[0].cyc == cyc) begin
      check($sformatf("fetch_c%0d", cyc), probe.adr, fq[0].adr);
      void'(fq.pop_front());
    end
    if (probe.we) begin
      if (wq.size() == 0) begin
        check($sformatf("unexpected_we_c%0d", cyc), {31'b0, probe.we}, 32'h0);
      end else begin
        wr_t e = wq.pop_front();
        check($sformatf("wr_cycle_%0h", e.adr), 32'(cyc), 32'(e.cyc));
        check($sformatf("wr_adr_%0h", e.adr), probe.adr, e.adr);
        check($sformatf("wr_data_%0h", e.adr), probe.wd, e.data);
      end
    end
  endtask

  initial begin
    load_program();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_adr", probe.adr, 32'h0);
    check("reset_we", {31'b0, probe.we}, 32'h0);
    cyc = 0;
    sample();
    repeat (120) begin
      @(negedge clk);
      cyc++;
      sample();
    end
    check("writes_pending", 32'(wq.size()), 32'h0);
    check("fetches_pending", 32'(fq.size()), 32'h0);

    // Restart, then abort the first sw while it is in MEMWR.
    dut.ram[19] = 32'hdeadbeef;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (11) @(negedge clk);
    check("memwr_we", {31'b0, probe.we}, 32'h1);
    check("memwr_adr", probe.adr, 32'h4c);
    reset = 1'b1;
    #1;
    check("abort_we", {31'b0, probe.we}, 32'h0);
    check("abort_adr", probe.adr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("restart_adr", probe.adr, 32'h0);
    check("restart_we", {31'b0, probe.we}, 32'h0);
    check("abort_no_write", dut.ram[19], 32'hdeadbeef);
    repeat (4) @(negedge clk);
    check("restart_fetch2", probe.adr, 32'h4);
    repeat (7) @(negedge clk);
    check("rerun_we", {31'b0, probe.we}, 32'h1);
    check("rerun_adr", probe.adr, 32'h4c);
    check("rerun_data", probe.wd, 32'd5);
    @(negedge clk);
    check("rerun_we_drop", {31'b0, probe.we}, 32'h0);
    check("rerun_stored", dut.ram[19], 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
